de2i_150_qsys_nios2_qsys_div_cell: RTL and testbench

Iterative radix-2 restoring divider cell for the Nios II custom ALU path. It is the inverse-operation companion to the pipelined multiplier cell.
- Accepts a 32-bit dividend/divisor pair with a start pulse.
- Produces quotient and remainder after a fixed latency.
- Signals completion with a one-cycle done pulse.
- Sits beside the multiplier cell in the CPU's A-stage execute unit; the CPU stalls on busy.

---
 rtl/de2i_150_qsys_nios2_qsys_div_cell_if.sv | 36 +++
 rtl/de2i_150_qsys_nios2_qsys_div_cell.sv | 168 ++++++++++++++++
 tb/tb_de2i_150_qsys_nios2_qsys_div_cell.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/de2i_150_qsys_nios2_qsys_div_cell_if.sv
// Request/response bundle between the A-stage execute unit and the divider cell.
// The CPU side is the master; the divider cell is the slave.
interface de2i_150_qsys_nios2_qsys_div_cell_if #(
    parameter int unsigned WIDTH = 32
);
    logic [WIDTH-1:0] A_div_src1;
    logic [WIDTH-1:0] A_div_src2;
    logic             A_div_signed;
    logic             A_div_start;
    logic             A_div_busy;
    logic             A_div_done;
    logic [WIDTH-1:0] A_div_quotient;
    logic [WIDTH-1:0] A_div_remainder;

    modport master (
        output A_div_src1,
        output A_div_src2,
        output A_div_signed,
        output A_div_start,
        input  A_div_busy,
        input  A_div_done,
        input  A_div_quotient,
        input  A_div_remainder
    );

    modport slave (
        input  A_div_src1,
        input  A_div_src2,
        input  A_div_signed,
        input  A_div_start,
        output A_div_busy,
        output A_div_done,
        output A_div_quotient,
        output A_div_remainder
    );
endinterface

// File: rtl/de2i_150_qsys_nios2_qsys_div_cell.sv
// Iterative radix-2 restoring divider for the Nios II custom ALU path.
// One start pulse in cycle N produces a one-cycle done pulse in cycle N+WIDTH+2,
// with busy high for the WIDTH+1 cycles in between. Signed mode is truncating:
// the quotient rounds toward zero and the remainder takes the dividend's sign.
module de2i_150_qsys_nios2_qsys_div_cell #(
    parameter int unsigned WIDTH = 32
) (
    input logic clk,
    input logic reset_n,
    de2i_150_qsys_nios2_qsys_div_cell_if.slave div_bus
);

    localparam int unsigned CntW = $clog2(WIDTH);
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StPrep = 2'd1;
    localparam logic [1:0] StIter = 2'd2;
    localparam logic [1:0] StFix  = 2'd3;

    logic [1:0]       state_q, state_d;

    // Operands captured with start; later changes on the bus are ignored.
    logic [WIDTH-1:0] src1_q;
    logic [WIDTH-1:0] src2_q;
    logic             sgn_q;

    logic             q_neg_q;
    logic             r_neg_q;
    logic             div0_q;

    // Partial remainder, dividend/quotient shift register and magnitude divisor.
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] dvd_q;
    logic [WIDTH-1:0] dvs_q;
    logic [CntW-1:0]  cnt_q;

    logic [WIDTH-1:0] quotient_q;
    logic [WIDTH-1:0] remainder_q;
    logic             done_q;

    logic [WIDTH-1:0] abs1;
    logic [WIDTH-1:0] abs2;
    logic [WIDTH-1:0] step_rem;
    logic [WIDTH-1:0] step_dvd;
    logic [WIDTH-1:0] step_dvs;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic             qbit;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] dvd_next;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;

    // Operand magnitudes; unsigned mode passes the raw bits through.
    always_comb begin
        abs1 = (sgn_q && src1_q[WIDTH-1]) ? (~src1_q + 1'b1) : src1_q;
        abs2 = (sgn_q && src2_q[WIDTH-1]) ? (~src2_q + 1'b1) : src2_q;
    end

    // One restoring step. PREP feeds it the fresh magnitudes so that the first
    // quotient bit is produced there, keeping the total latency at WIDTH+2.
    always_comb begin
        if (state_q == StPrep) begin
            step_rem = '0;
            step_dvd = abs1;
            step_dvs = abs2;
        end else begin
            step_rem = rem_q;
            step_dvd = dvd_q;
            step_dvs = dvs_q;
        end
        shifted  = {step_rem, step_dvd[WIDTH-1]};
        trial    = shifted - {1'b0, step_dvs};
        qbit     = ~trial[WIDTH];
        rem_next = qbit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
        dvd_next = {step_dvd[WIDTH-2:0], qbit};
    end

    // Sign fix-up and divide-by-zero override applied when the results are latched.
    always_comb begin
        if (div0_q) begin
            q_fix = '1;
            r_fix = src1_q;
        end else begin
            q_fix = q_neg_q ? (~dvd_q + 1'b1) : dvd_q;
            r_fix = r_neg_q ? (~rem_q + 1'b1) : rem_q;
        end
    end

    // Sequencing: IDLE -> PREP -> ITER (WIDTH-1 cycles) -> FIX -> IDLE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (div_bus.A_div_start) state_d = StPrep;
            StPrep: state_d = StIter;
            StIter: if (cnt_q == CntLast) state_d = StFix;
            StFix:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath: capture, iterate, and latch results; done is a single-cycle pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            src1_q      <= '0;
            src2_q      <= '0;
            sgn_q       <= 1'b0;
            q_neg_q     <= 1'b0;
            r_neg_q     <= 1'b0;
            div0_q      <= 1'b0;
            rem_q       <= '0;
            dvd_q       <= '0;
            dvs_q       <= '0;
            cnt_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (div_bus.A_div_start) begin
                        src1_q <= div_bus.A_div_src1;
                        src2_q <= div_bus.A_div_src2;
                        sgn_q  <= div_bus.A_div_signed;
                    end
                end
                StPrep: begin
                    q_neg_q <= sgn_q & (src1_q[WIDTH-1] ^ src2_q[WIDTH-1]);
                    r_neg_q <= sgn_q & src1_q[WIDTH-1];
                    div0_q  <= (src2_q == '0);
                    dvs_q   <= abs2;
                    rem_q   <= rem_next;
                    dvd_q   <= dvd_next;
                    // Iteration 0 already happened here, so the count starts at 1.
                    cnt_q   <= CntW'(1);
                end
                StIter: begin
                    rem_q <= rem_next;
                    dvd_q <= dvd_next;
                    cnt_q <= cnt_q + 1'b1;
                end
                StFix: begin
                    quotient_q  <= q_fix;
                    remainder_q <= r_fix;
                    done_q      <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign div_bus.A_div_busy      = (state_q != StIdle);
    assign div_bus.A_div_done      = done_q;
    assign div_bus.A_div_quotient  = quotient_q;
    assign div_bus.A_div_remainder = remainder_q;

endmodule

// File: tb/tb_de2i_150_qsys_nios2_qsys_div_cell.sv
// Directed and light random bench for the divider cell. Expected results are
// queued at start and checked against the DUT when done pulses.
module tb_de2i_150_qsys_nios2_qsys_div_cell;

    localparam int unsigned WIDTH = 32;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    always #5 clk = ~clk;

    de2i_150_qsys_nios2_qsys_div_cell_if #(.WIDTH(WIDTH)) div_bus ();

    de2i_150_qsys_nios2_qsys_div_cell #(.WIDTH(WIDTH)) u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .div_bus (div_bus)
    );

    typedef struct packed {
        logic [31:0] q;
        logic [31:0] r;
    } exp_t;

    exp_t  sb[$];
    int    n_vec  = 0;
    int    n_err  = 0;
    int    n_done = 0;
    string cur_tag = "reset";

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
        end
    endtask

    // Scoreboard side: every done pulse must match the oldest outstanding request.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (reset_n && div_bus.A_div_done) begin
            n_done++;
            if (sb.size() == 0) begin
                check({cur_tag, " done_without_request"}, {31'b0, div_bus.A_div_done}, 32'd0);
            end else begin
                e = sb.pop_front();
                check({cur_tag, " quotient"}, div_bus.A_div_quotient, e.q);
                check({cur_tag, " remainder"}, div_bus.A_div_remainder, e.r);
            end
        end
    end

    // Drive one start cycle; call away from the rising edge. Operands are
    // scrambled right after the start cycle to show they are not re-sampled.
    task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                            input bit push, input logic [31:0] eq, input logic [31:0] er);
        div_bus.A_div_src1   = a;
        div_bus.A_div_src2   = b;
        div_bus.A_div_signed = s;
        div_bus.A_div_start  = 1'b1;
        if (push) sb.push_back(exp_t'{q: eq, r: er});
        @(posedge clk);
        #1;
        div_bus.A_div_start  = 1'b0;
        div_bus.A_div_src1   = $urandom;
        div_bus.A_div_src2   = $urandom;
        div_bus.A_div_signed = 1'($urandom_range(0, 1));
    endtask

    // Counts cycles (first negedge is cycle k0 after the start cycle) until done.
    task automatic wait_done(input int k0, output int lat, output int nbusy);
        lat = 0;
        nbusy = 0;
        for (int k = k0; k < k0 + 60; k++) begin
            @(negedge clk);
            if (div_bus.A_div_busy) nbusy++;
            if (div_bus.A_div_done) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic s, input logic [31:0] eq, input logic [31:0] er);
        int lat;
        int nb;
        cur_tag = tag;
        start_op(a, b, s, 1'b1, eq, er);
        wait_done(1, lat, nb);
        check({tag, " latency"}, lat, 32'd34);
        check({tag, " busy_cycles"}, nb, 32'd33);
        @(posedge clk);
        #1;
    endtask

    initial begin : stim
        int lat;
        int nb;
        int done_before;
        logic [31:0] a;
        logic [31:0] b;
        logic signed [31:0] sa;
        logic signed [31:0] sbv;
        logic signed [31:0] sq;
        logic signed [31:0] sr;

        div_bus.A_div_src1   = '0;
        div_bus.A_div_src2   = '0;
        div_bus.A_div_signed = 1'b0;
        div_bus.A_div_start  = 1'b0;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", {31'b0, div_bus.A_div_busy}, 32'd0);
        check("reset done", {31'b0, div_bus.A_div_done}, 32'd0);
        check("reset quotient", div_bus.A_div_quotient, 32'd0);
        check("reset remainder", div_bus.A_div_remainder, 32'd0);
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Unsigned basic, then confirm done is a single-cycle pulse.
        run_op("u100/7", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2);
        @(negedge clk);
        check("done_pulse_width", {31'b0, div_bus.A_div_done}, 32'd0);
        check("quotient_hold", div_bus.A_div_quotient, 32'd14);
        @(posedge clk);
        #1;

        // Signed mixed signs.
        run_op("s-100/7", 32'hFFFF_FF9C, 32'd7, 1'b1, 32'hFFFF_FFF2, 32'hFFFF_FFFE);
        run_op("s-100/-7", 32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b1, 32'd14, 32'hFFFF_FFFE);

        // Overflow wrap and unsigned max.
        run_op("s_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0);
        run_op("u_max", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0, 32'h8000_0000);

        // Divide by zero in both modes.
        run_op("u5/0", 32'd5, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'd5);
        run_op("s5/0", 32'd5, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'd5);

        // Second start at N+10 is ignored.
        cur_tag = "ignore";
        start_op(32'd50, 32'd5, 1'b0, 1'b1, 32'd10, 32'd0);
        repeat (9) @(posedge clk);
        #1;
        start_op(32'd7, 32'd7, 1'b0, 1'b0, 32'd0, 32'd0);
        wait_done(11, lat, nb);
        check("ignore latency", lat, 32'd34);
        check("ignore busy_cycles", nb, 32'd23);

        // Start in the done cycle is accepted; first result holds meanwhile.
        cur_tag = "b2b";
        start_op(32'd1000, 32'd10, 1'b0, 1'b1, 32'd100, 32'd0);
        check("b2b held_quotient", div_bus.A_div_quotient, 32'd10);
        check("b2b busy_after_start", {31'b0, div_bus.A_div_busy}, 32'd1);
        wait_done(1, lat, nb);
        check("b2b latency", lat, 32'd34);
        @(posedge clk);
        #1;

        // Reset mid-operation at N+15 for two cycles.
        cur_tag = "abort";
        start_op(32'd12345, 32'd7, 1'b0, 1'b0, 32'd0, 32'd0);
        repeat (14) @(posedge clk);
        #1;
        check("abort busy_before", {31'b0, div_bus.A_div_busy}, 32'd1);
        reset_n = 1'b0;
        #1;
        check("abort busy", {31'b0, div_bus.A_div_busy}, 32'd0);
        check("abort done", {31'b0, div_bus.A_div_done}, 32'd0);
        check("abort quotient", div_bus.A_div_quotient, 32'd0);
        check("abort remainder", div_bus.A_div_remainder, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        done_before = n_done;
        repeat (40) @(negedge clk);
        check("abort no_done", n_done - done_before, 32'd0);
        @(posedge clk);
        #1;
        run_op("u9/3", 32'd9, 32'd3, 1'b0, 32'd3, 32'd0);

        // Random unsigned operands against a reference computed here.
        for (int i = 0; i < 4; i++) begin
            a = $urandom;
            b = $urandom_range(1, 65535);
            run_op("u_rand", a, b, 1'b0, a / b, a % b);
        end

        // Random signed operands, steering clear of zero and the overflow pair.
        for (int i = 0; i < 4; i++) begin
            sa  = $urandom;
            sbv = $urandom;
            if (i[0]) sbv = sbv >>> 20;
            if (sbv == 0) sbv = 3;
            if (sbv == -1) sbv = -5;
            sq = sa / sbv;
            sr = sa % sbv;
            run_op("s_rand", sa, sbv, 1'b1, sq, sr);
        end

        repeat (3) @(posedge clk);
        check("scoreboard_drained", sb.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
